upload_arbiter: RTL and testbench

Packet-level arbiter that shares the command processor's single upload channel among up to NUM_SRC handler upload ports (UART, SPI, DSM, I2C, …), replacing the OR/priority-mux merge in the CDC top level. Each handler asserts a request for the duration of one upload packet. The arbiter grants one source at a time in round-robin order and locks the grant until that source drops its request. It then inserts a one-cycle gap so the processor sees a clean packet boundary. A watchdog releases a source that holds its request without moving data.

---
 rtl/upload_arbiter.sv | 147 ++++++++++++++
 tb/tb_upload_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upload_arbiter.sv
// Round-robin, packet-locked arbiter merging several handler upload ports onto the single
// command-processor upload channel, with a one-cycle inter-packet gap and a stall watchdog.
module upload_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC-1:0]          src_req_i,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data_i,
  input  logic [NUM_SRC*DATA_W-1:0]   src_source_i,
  input  logic [NUM_SRC-1:0]          src_valid_i,
  output logic [NUM_SRC-1:0]          src_ready_o,
  output logic                        up_req_o,
  output logic [DATA_W-1:0]           up_data_o,
  output logic [DATA_W-1:0]           up_source_o,
  output logic                        up_valid_o,
  input  logic                        up_ready_i,
  output logic [$clog2(NUM_SRC)-1:0]  grant_id_o,
  output logic                        busy_o,
  output logic                        timeout_err_o
);

  localparam int unsigned IdW = $clog2(NUM_SRC);
  localparam int unsigned WdW = $clog2(TIMEOUT);
  localparam logic [WdW-1:0] WdMax   = WdW'(TIMEOUT - 1);
  localparam logic [IdW-1:0] LastRst = IdW'(NUM_SRC - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     grant_q, grant_d;
  logic [IdW-1:0]     last_q, last_d;
  logic [WdW-1:0]     wd_q, wd_d;

  logic               req_any;
  logic [IdW-1:0]     winner;
  logic               g_req, g_valid;
  logic [DATA_W-1:0]  g_data, g_source;
  logic               beat, pkt_end, wd_expire;

  assign req_any = |src_req_i;

  // Search upward from the slot after the last grant, wrapping, so every requester gets a turn.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx    = 0;
    found  = 1'b0;
    winner = last_q;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(last_q) + k) % NUM_SRC;
      if (!found && src_req_i[IdW'(idx)]) begin
        found  = 1'b1;
        winner = IdW'(idx);
      end
    end
  end

  // Lane of the currently granted source.
  always_comb begin
    g_req    = 1'b0;
    g_valid  = 1'b0;
    g_data   = '0;
    g_source = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IdW'(i)) begin
        g_req    = src_req_i[i];
        g_valid  = src_valid_i[i];
        g_data   = src_data_i[i*DATA_W +: DATA_W];
        g_source = src_source_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign beat      = (state_q == StXfer) && g_valid && up_ready_i;
  assign pkt_end   = (state_q == StXfer) && !g_req && !g_valid;
  // Clean packet end wins over the watchdog; a beat taken this cycle counts as progress.
  assign wd_expire = (state_q == StXfer) && !pkt_end && !beat && (wd_q == WdMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= LastRst;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          state_d = StXfer;
          grant_d = winner;
          last_d  = winner;
          wd_d    = '0;
        end
      end
      StXfer: begin
        if (pkt_end || wd_expire) begin
          state_d = StGap;
        end else if (beat) begin
          wd_d = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    src_ready_o   = '0;
    up_req_o      = 1'b0;
    up_valid_o    = 1'b0;
    up_data_o     = '0;
    up_source_o   = '0;
    busy_o        = (state_q != StIdle);
    timeout_err_o = wd_expire;
    if (state_q == StXfer) begin
      up_req_o             = g_req;
      up_valid_o           = g_valid;
      up_data_o            = g_data;
      up_source_o          = g_source;
      src_ready_o[grant_q] = up_ready_i;
    end
  end

  assign grant_id_o = grant_q;

endmodule

// File: tb/tb_upload_arbiter.sv
// Randomised and scripted bench for upload_arbiter; every cycle is compared against an
// owner/gap reference model of the arbitration rules.
module tb_upload_arbiter;

  localparam int NS  = 4;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NS-1:0]      src_req = '0, src_valid = '0, src_ready;
  logic [NS*DW-1:0]   src_data = '0, src_source = '0;
  logic               up_req, up_valid, busy, timeout_err;
  logic               up_ready = 1'b0;
  logic [DW-1:0]      up_data, up_source;
  logic [1:0]         grant_id;

  always #5 clk = ~clk;

  upload_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_req_i    (src_req),
    .src_data_i   (src_data),
    .src_source_i (src_source),
    .src_valid_i  (src_valid),
    .src_ready_o  (src_ready),
    .up_req_o     (up_req),
    .up_data_o    (up_data),
    .up_source_o  (up_source),
    .up_valid_o   (up_valid),
    .up_ready_i   (up_ready),
    .grant_id_o   (grant_id),
    .busy_o       (busy),
    .timeout_err_o(timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Handler behaviour
  bit        rand_mode, rst_drv, rdy_drv;
  bit        req_a[NS], val_a[NS];
  logic [7:0] dat_a[NS], tag_a[NS], d0_a[NS];
  int        left_a[NS], stall_a[NS], stall_len_a[NS], pkts_a[NS], plen_a[NS];

  // Reference model: who owns the channel, whether we are in the gap cycle
  int m_owner, m_gap, m_last, m_gid, m_quiet;

  int         grants_q[$];
  logic [7:0] beats_q[$];
  int         tmo_cnt;
  bit         prev_busy;

  task automatic model_reset();
    m_owner = -1;
    m_gap   = 0;
    m_last  = NS - 1;
    m_gid   = 0;
    m_quiet = 0;
  endtask

  task automatic start_pkt(input int i);
    req_a[i]   = 1'b1;
    left_a[i]  = plen_a[i];
    stall_a[i] = stall_len_a[i];
    dat_a[i]   = rand_mode ? 8'($urandom) : d0_a[i];
    val_a[i]   = (stall_a[i] > 0) ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  task automatic tick(input int i, input bit accepted, input bit granted);
    if (req_a[i] && stall_a[i] > 0) begin
      stall_a[i]--;
      val_a[i] = 1'b0;
      if (stall_a[i] == 0) req_a[i] = 1'b0;
    end else if (req_a[i] || val_a[i]) begin
      if (accepted) begin
        left_a[i]--;
        if (left_a[i] <= 0) begin
          req_a[i] = 1'b0;
          val_a[i] = 1'b0;
        end else begin
          dat_a[i] = rand_mode ? 8'($urandom) : dat_a[i] + 8'd1;
          val_a[i] = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end else if (!val_a[i] && left_a[i] > 0) begin
        val_a[i] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (rand_mode && granted && left_a[i] == 1 && val_a[i] && req_a[i] &&
          $urandom_range(0, 3) == 0) req_a[i] = 1'b0;
      if (rand_mode && !granted && !req_a[i] && val_a[i]) begin
        val_a[i]  = 1'b0;
        left_a[i] = 0;
      end
    end else if (pkts_a[i] > 0) begin
      pkts_a[i]--;
      start_pkt(i);
    end else if (rand_mode && $urandom_range(0, 7) == 0) begin
      plen_a[i]      = $urandom_range(1, 5);
      tag_a[i]       = 8'($urandom);
      stall_len_a[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(18, 30) : 0;
      start_pkt(i);
    end
  endtask

  task automatic step();
    bit         e_req, e_val, e_busy, e_tmo, beat, endp;
    logic [7:0] e_dat, e_tag;
    logic [3:0] e_rdy;
    int         acc, gnt;
    @(posedge clk);
    #1;
    rst_n    = rst_drv;
    up_ready = rdy_drv;
    for (int i = 0; i < NS; i++) begin
      src_req[i]               = req_a[i];
      src_valid[i]             = val_a[i];
      src_data[i*DW +: DW]     = dat_a[i];
      src_source[i*DW +: DW]   = tag_a[i];
    end
    @(negedge clk);
    e_req = 0; e_val = 0; e_busy = 0; e_tmo = 0; e_dat = '0; e_tag = '0; e_rdy = '0;
    beat = 0; endp = 0; acc = -1;
    if (!rst_n) model_reset();
    gnt = m_owner;
    if (m_owner >= 0) begin
      e_req        = req_a[m_owner];
      e_val        = val_a[m_owner];
      e_dat        = dat_a[m_owner];
      e_tag        = tag_a[m_owner];
      e_rdy[m_owner] = up_ready;
      e_busy       = 1;
      beat         = e_val && up_ready;
      endp         = !e_req && !e_val;
      e_tmo        = !endp && !beat && (m_quiet == TMO - 1);
    end else if (m_gap != 0) begin
      e_busy = 1;
    end
    check_eq("up_req", up_req, e_req);
    check_eq("up_valid", up_valid, e_val);
    check_eq("up_data", up_data, e_dat);
    check_eq("up_source", up_source, e_tag);
    check_eq("src_ready", src_ready, e_rdy);
    check_eq("grant_id", grant_id, m_gid);
    check_eq("busy", busy, e_busy);
    check_eq("timeout_err", timeout_err, e_tmo);
    if (rst_n && busy && !prev_busy) grants_q.push_back(int'(grant_id));
    prev_busy = busy;
    if (up_valid && up_ready) beats_q.push_back(up_data);
    if (timeout_err) tmo_cnt++;
    if (rst_n) begin
      if (m_owner >= 0) begin
        if (beat) acc = m_owner;
        if (endp || e_tmo) begin
          m_owner = -1;
          m_gap   = 1;
        end else begin
          m_quiet = beat ? 0 : m_quiet + 1;
        end
      end else if (m_gap != 0) begin
        m_gap = 0;
      end else begin
        for (int k = 1; k <= NS; k++) begin
          int w;
          w = (m_last + k) % NS;
          if (m_owner < 0 && req_a[w]) begin
            m_owner = w;
            m_last  = w;
            m_gid   = w;
            m_quiet = 0;
          end
        end
      end
    end
    for (int i = 0; i < NS; i++) tick(i, acc == i, gnt == i);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NS; i++) begin
      req_a[i] = 0; val_a[i] = 0; dat_a[i] = '0; tag_a[i] = '0; d0_a[i] = '0;
      left_a[i] = 0; stall_a[i] = 0; stall_len_a[i] = 0; pkts_a[i] = 0; plen_a[i] = 0;
    end
    rdy_drv = 1;
    rst_drv = 0;
    run(2);
    rst_drv = 1;
    grants_q.delete();
    beats_q.delete();
    tmo_cnt   = 0;
    prev_busy = 0;
  endtask

  task automatic chk_grant(input string tag, input int idx, input int exp);
    check_eq(tag, (idx < grants_q.size()) ? grants_q[idx] : -1, exp);
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [7:0] exp);
    check_eq(tag, (idx < beats_q.size()) ? 32'(beats_q[idx]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  initial begin
    rand_mode = 0;
    model_reset();
    do_reset();

    // Single source, three beats
    plen_a[1] = 3; d0_a[1] = 8'hA1; tag_a[1] = 8'h03; pkts_a[1] = 1;
    run(12);
    check_eq("single_nbeats", beats_q.size(), 3);
    chk_beat("single_b0", 0, 8'hA1);
    chk_beat("single_b1", 1, 8'hA2);
    chk_beat("single_b2", 2, 8'hA3);
    check_eq("single_ngrants", grants_q.size(), 1);
    chk_grant("single_g0", 0, 1);

    // Round-robin, src 0 re-requests
    do_reset();
    plen_a[0] = 2; plen_a[2] = 2; plen_a[3] = 2;
    d0_a[0] = 8'h01; d0_a[2] = 8'h21; d0_a[3] = 8'h31;
    tag_a[0] = 8'h10; tag_a[2] = 8'h12; tag_a[3] = 8'h13;
    pkts_a[0] = 2; pkts_a[2] = 1; pkts_a[3] = 1;
    run(40);
    check_eq("rr_ngrants", grants_q.size(), 4);
    chk_grant("rr_g0", 0, 0);
    chk_grant("rr_g1", 1, 2);
    chk_grant("rr_g2", 2, 3);
    chk_grant("rr_g3", 3, 0);

    // Backpressure while 0x55 is presented
    do_reset();
    plen_a[2] = 3; d0_a[2] = 8'h54; tag_a[2] = 8'h02; pkts_a[2] = 1;
    run(3);
    rdy_drv = 0;
    run(5);
    rdy_drv = 1;
    run(10);
    check_eq("bp_nbeats", beats_q.size(), 3);
    chk_beat("bp_b0", 0, 8'h54);
    chk_beat("bp_b1", 1, 8'h55);
    chk_beat("bp_b2", 2, 8'h56);
    check_eq("bp_no_timeout", tmo_cnt, 0);

    // Watchdog on a stalled src 3, then pending src 0
    do_reset();
    stall_len_a[3] = 20; tag_a[3] = 8'h33; pkts_a[3] = 1;
    run(2);
    plen_a[0] = 2; d0_a[0] = 8'h40; tag_a[0] = 8'h30; pkts_a[0] = 1;
    run(40);
    check_eq("wd_pulses", tmo_cnt, 1);
    check_eq("wd_ngrants", grants_q.size(), 2);
    chk_grant("wd_g0", 0, 3);
    chk_grant("wd_g1", 1, 0);
    chk_beat("wd_b0", 0, 8'h40);

    // Isolation: src 1 toggles valid without a grant
    do_reset();
    plen_a[0] = 4; d0_a[0] = 8'h10; tag_a[0] = 8'h0A; pkts_a[0] = 1;
    dat_a[1] = 8'hEE; tag_a[1] = 8'h77;
    for (int c = 0; c < 12; c++) begin
      val_a[1] = ~val_a[1];
      step();
    end
    val_a[1] = 0;
    run(4);
    check_eq("iso_nbeats", beats_q.size(), 4);
    chk_beat("iso_b0", 0, 8'h10);
    chk_beat("iso_b3", 3, 8'h13);
    check_eq("iso_ngrants", grants_q.size(), 1);

    // Reset during the second beat of src 2
    do_reset();
    plen_a[2] = 3; d0_a[2] = 8'h20; tag_a[2] = 8'h22; pkts_a[2] = 1;
    run(3);
    rst_drv = 0;
    plen_a[0] = 1; d0_a[0] = 8'h30; tag_a[0] = 8'h20; pkts_a[0] = 1;
    run(2);
    rst_drv = 1;
    grants_q.delete();
    beats_q.delete();
    prev_busy = 0;
    run(25);
    check_eq("rst_ngrants", grants_q.size(), 2);
    chk_grant("rst_g0", 0, 0);
    chk_grant("rst_g1", 1, 2);
    chk_beat("rst_b0", 0, 8'h30);
    chk_beat("rst_b1", 1, 8'h21);
    chk_beat("rst_b2", 2, 8'h22);

    // Random traffic with a reset in the middle
    do_reset();
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      rdy_drv = ($urandom_range(0, 3) != 0);
      rst_drv = !(c >= 1500 && c < 1502);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
